run_scan_ctrl: RTL and testbench

Bit-serial scan controller that sequences a Moore two-consecutive-ones run detector over a parallel word. It accepts a WIDTH-bit word on a start pulse and shifts it LSB-first into the detector. It counts the cycles in which the detector output is high and reports the count with a one-cycle done pulse. It sits between a parallel producer and the shared run-detector datapath, so software-visible words can be checked for adjacent-ones pairs.

---
 rtl/run_scan_pkg.sv | 31 +++
 rtl/run_detect_moore.sv | 41 ++++
 rtl/run_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_run_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/run_scan_pkg.sv
// Shared encodings and helpers for the run-scan controller and its detector.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package run_scan_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FLUSH = 2'b10,
        DONE  = 2'b11
    } ctrl_state_t;

    // Detector states; 2'b11 is unused and recovers to ZERO
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        ONE1  = 2'b01,
        TWO1S = 2'b10
    } det_state_t;

    // Ceiling log2 for constant sizing; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/run_detect_moore.sv
// Moore detector: out is high while the last two inputs were both 1.
// Latency: out reflects the input sampled at the previous rising edge.
// Backpressure: none; consumes one bit every cycle, clr overrides in.
module run_detect_moore
    import run_scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic in,
    output logic out
);

    det_state_t state;
    det_state_t next_state;

    // State register, asynchronous reset to ZERO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ZERO;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; clr wins over in, unused encoding falls back to ZERO
    always_comb begin
        next_state = ZERO;
        if (!clr) begin
            case (state)
                ZERO:    next_state = in ? ONE1  : ZERO;
                ONE1:    next_state = in ? TWO1S : ZERO;
                TWO1S:   next_state = in ? TWO1S : ZERO;
                default: next_state = ZERO;
            endcase
        end
    end

    assign out = (state == TWO1S);

endmodule

// File: rtl/run_scan_ctrl.sv
// Scans a WIDTH-bit word LSB-first through a run detector and counts adjacent-ones pairs.
// Latency: done pulses WIDTH+2 cycles after start is accepted; repeat period WIDTH+3.
// Backpressure: start is honoured only in IDLE; requests while busy or done are dropped.
module run_scan_ctrl
    import run_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             found
);

    // Bit counter must hold 0..WIDTH-1, and at least one bit wide
    localparam int BW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    // Reject illegal parameterisations at elaboration
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("run_scan_ctrl: WIDTH must lie in 2..32");
    end
    if ((2 ** CNT_W) <= (WIDTH - 1)) begin : g_bad_cnt_w
        $error("run_scan_ctrl: CNT_W too narrow to hold WIDTH-1");
    end

    ctrl_state_t      state;
    ctrl_state_t      next_state;
    logic [WIDTH-1:0] shift_reg;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic             found_q;
    logic             det_clr;
    logic             det_in;
    logic             det_out;

    run_detect_moore u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr),
        .in    (det_in),
        .out   (det_out)
    );

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and detector drive; detector sees 0 outside SHIFT
    always_comb begin
        next_state = state;
        det_clr    = 1'b0;
        det_in     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    det_clr    = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                det_in = shift_reg[0];
                if (bit_cnt == LAST_BIT) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: word capture, shifting, bit counting and pair accumulation.
    // The detector output lags its input by one edge, so the pair formed by
    // the last two bits is only visible during FLUSH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            count_q   <= '0;
            found_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= data_in;
                        bit_cnt   <= '0;
                        count_q   <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= bit_cnt + BW'(1);
                    if (det_out) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    if (det_out) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    found_q <= (count_q != '0);
                end
                default: begin
                    shift_reg <= shift_reg;
                end
            endcase
        end
    end

    // Registered status outputs, one cycle behind the controller state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state == SHIFT) || (state == FLUSH);
            done_q <= (state == DONE);
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;
    assign found = found_q;

endmodule

// File: tb/tb_run_scan_ctrl.sv
// Directed bench for run_scan_ctrl at WIDTH=8/CNT_W=4 and WIDTH=2/CNT_W=1.
// Latency: checks done at WIDTH+2 edges after acceptance, busy for WIDTH+1 cycles.
// Backpressure: checks that start held high is ignored until the controller is IDLE.
module tb_run_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic       found;

    logic       s2_start;
    logic [1:0] s2_data;
    logic       s2_busy;
    logic       s2_done;
    logic [0:0] s2_count;
    logic       s2_found;

    int tests_run;
    int fails;

    run_scan_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .found   (found)
    );

    run_scan_ctrl #(.WIDTH(2), .CNT_W(1)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .start   (s2_start),
        .data_in (s2_data),
        .busy    (s2_busy),
        .done    (s2_done),
        .count   (s2_count),
        .found   (s2_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        data_in  = 8'h00;
        s2_start = 1'b0;
        s2_data  = 2'b00;
        repeat (2) tick();
        tests_run++;
        if ({busy, done, count, found} !== 7'd0) begin
            fails++;
            $display("FAIL reset_hold: busy/done/count/found=%b expected 0", {busy, done, count, found});
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            tests_run++;
            if ({busy, done, count, found} !== 7'd0) begin
                fails++;
                $display("FAIL idle_cycle%0d: busy/done/count/found=%b expected 0", c, {busy, done, count, found});
            end
        end
    endtask

    // start and data_in must already be driven; the next edge accepts
    task automatic scan_body(input logic [3:0] exp_cnt, input string name);
        int busy_n;
        int done_n;
        int done_at;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = k;
                tests_run++;
                if (count !== exp_cnt || found !== (exp_cnt != 4'd0)) begin
                    fails++;
                    $display("FAIL %s_result: count=%0d found=%0d expected count=%0d found=%0d",
                             name, count, found, exp_cnt, (exp_cnt != 4'd0));
                end
            end
        end
        tests_run++;
        if (done_n != 1 || done_at != 10) begin
            fails++;
            $display("FAIL %s_done: pulses=%0d at=%0d expected 1 at 10", name, done_n, done_at);
        end
        tests_run++;
        if (busy_n != 9) begin
            fails++;
            $display("FAIL %s_busy: cycles=%0d expected 9", name, busy_n);
        end
        tests_run++;
        if (count !== exp_cnt) begin
            fails++;
            $display("FAIL %s_hold: count=%0d expected %0d", name, count, exp_cnt);
        end
    endtask

    task automatic run_scan(input logic [7:0] word, input logic [3:0] exp_cnt, input string name);
        data_in = word;
        start   = 1'b1;
        scan_body(exp_cnt, name);
    endtask

    task automatic test_words();
        run_scan(8'h07, 4'd2, "w07");
        run_scan(8'hFF, 4'd7, "wFF");
        run_scan(8'h55, 4'd0, "w55");
        run_scan(8'hC3, 4'd2, "wC3");
    endtask

    task automatic test_back_to_back();
        int   done_at[$];
        logic busy11;
        logic busy12;
        busy11  = 1'b1;
        busy12  = 1'b0;
        data_in = 8'h03;
        start   = 1'b1;
        tick();
        data_in = 8'h80;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 11) busy11 = busy;
            if (k == 12) busy12 = busy;
            if (done) begin
                done_at.push_back(k);
                tests_run++;
                if (done_at.size() == 1 && (count !== 4'd1 || found !== 1'b1)) begin
                    fails++;
                    $display("FAIL b2b_first: count=%0d found=%0d expected 1/1", count, found);
                end else if (done_at.size() == 2 && (count !== 4'd0 || found !== 1'b0)) begin
                    fails++;
                    $display("FAIL b2b_second: count=%0d found=%0d expected 0/0", count, found);
                end else if (done_at.size() > 2) begin
                    fails++;
                    $display("FAIL b2b_extra_done: at cycle %0d expected none", k);
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (done_at.size() != 2 || done_at[0] != 10 || done_at[1] != 21) begin
            fails++;
            $display("FAIL b2b_period: pulses=%0d expected done at 10 and 21", done_at.size());
        end
        tests_run++;
        if (busy11 !== 1'b0 || busy12 !== 1'b1) begin
            fails++;
            $display("FAIL b2b_reaccept: busy@11=%b busy@12=%b expected 0 then 1", busy11, busy12);
        end
        repeat (12) tick();
    endtask

    task automatic test_reset_mid_scan();
        data_in = 8'hFF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (busy !== 1'b1 || count !== 4'd2) begin
            fails++;
            $display("FAIL mid_progress: busy=%b count=%0d expected 1/2", busy, count);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, count, found} !== 7'd0) begin
            fails++;
            $display("FAIL mid_reset_async: busy/done/count/found=%b expected 0", {busy, done, count, found});
        end
        data_in = 8'h06;
        start   = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tests_run++;
        if ({busy, done, count, found} !== 7'd0) begin
            fails++;
            $display("FAIL mid_reset_release: busy/done/count/found=%b expected 0", {busy, done, count, found});
        end
        scan_body(4'd1, "post_reset_w06");
    endtask

    task automatic test_width2();
        logic [1:0] words [2];
        logic [0:0] exps  [2];
        words[0] = 2'b11; exps[0] = 1'b1;
        words[1] = 2'b10; exps[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            int done_at;
            int busy_n;
            done_at  = -1;
            busy_n   = 0;
            s2_data  = words[t];
            s2_start = 1'b1;
            tick();
            s2_start = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                tick();
                if (s2_busy) busy_n++;
                if (s2_done) begin
                    done_at = k;
                    tests_run++;
                    if (s2_count !== exps[t] || s2_found !== exps[t][0]) begin
                        fails++;
                        $display("FAIL w2_result%0d: count=%0d found=%0d expected %0d", t, s2_count, s2_found, exps[t]);
                    end
                end
            end
            tests_run++;
            if (done_at != 4 || busy_n != 3) begin
                fails++;
                $display("FAIL w2_timing%0d: done_at=%0d busy=%0d expected 4/3", t, done_at, busy_n);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_words();
        test_back_to_back();
        test_reset_mid_scan();
        test_width2();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
